hcp_register_group: RTL and testbench
=====================================

Name: hcp_register_group

Overview:
- Downstream register-group stage of the local access controller's HRG channel (hrg = HCP register group).
- Consumes single-word write/read accesses: 19-bit address, 32-bit data, addr_fix flag.
- Holds HCP global configuration registers, status registers and read-clear event counters.
- Returns read responses over the HRG response interface with fixed 2-cycle latency.
- Drives static configuration outputs and a timed soft-reset pulse to the rest of the HCP.

Parameters:
P_VERSION, 32'h0304_0000, value returned by VERSION register.
P_SLOT_DEFAULT, 16'd1024, reset value of SLOT_LEN.
P_PERIOD_DEFAULT, 16'd1000, reset value of REPORT_PERIOD.
P_SOFT_RST_CYCLES, 16, width in clocks of the soft-reset pulse (range 1..255).

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_hrg_wr  in  1  write strobe, one cycle per access
iv_hrg_wdata  in  32  write data
iv_hrg_addr  in  19  access address (write or read)
i_hrg_addr_fix  in  1  address-fix flag, echoed with read response
i_hrg_rd  in  1  read strobe, one cycle per access
o_hrg_wr  out  1  read-response valid
ov_hrg_raddr  out  19  address of the response
o_hrg_addr_fix  out  1  echoed addr_fix
ov_hrg_rdata  out  32  read data
i_cmd_event  in  1  pulse; increments CMD_CNT
iv_hw_state  in  4  live hardware state, shown in HW_STATE
ov_hcp_mid  out  12  HCP MID
o_cfg_finish  out  1  configuration-finished flag
o_report_en  out  1  state-report enable
ov_slot_len  out  16  time-slot length
ov_report_period  out  16  report period
o_soft_rst_n  out  1  soft-reset pulse, active low

Behaviour:
- Decode: access is valid only when iv_hrg_addr[18:4] == 0; index = addr[3:0].
- Register map:
  - 0x0 VERSION: RO.
  - 0x1 HCP_MID: RW [11:0]; bits [31:12] read 0.
  - 0x2 CTRL: RW; bit0 cfg_finish, bit1 report_en; other bits read 0.
  - 0x3 SLOT_LEN: RW [15:0].
  - 0x4 REPORT_PERIOD: RW [15:0].
  - 0x5 SOFT_RST: WO; reads 0.
  - 0x6 HW_STATE: RO {28'b0, iv_hw_state}, sampled in read stage 1.
  - 0x8 CMD_CNT: RO, read-clear.
  - 0x9 ERR_CNT: RO, read-clear.
  - All other indices are unmapped.
- Reset values:
  - All response outputs 0; o_soft_rst_n=1.
  - HCP_MID=0, CTRL=0, SLOT_LEN=P_SLOT_DEFAULT, REPORT_PERIOD=P_PERIOD_DEFAULT, both counters 0.
- Write path:
  - Register updates on the clock edge that samples i_hrg_wr; config outputs change the following cycle.
  - No response is generated for writes.
  - Error cases, each of which increments ERR_CNT and changes no state:
    - write to RO or unmapped address, or addr[18:4] != 0;
    - write to SOFT_RST with data != 32'h5A5A_A5A5.
- Soft reset:
  - Writing 32'h5A5A_A5A5 to SOFT_RST loads the down-counter with P_SOFT_RST_CYCLES.
  - o_soft_rst_n is 0 while counter != 0, from the cycle after the write.
  - A rewrite during an active pulse reloads the counter, extending the pulse.
  - Soft reset does not clear this block's registers.
- Read path, 2-stage pipeline:
  - Cycle N: strobe sampled.
  - Cycle N+1: decode and mux registered.
  - Cycle N+2: o_hrg_wr=1 with ov_hrg_raddr = the address from N, o_hrg_addr_fix echoed, ov_hrg_rdata.
  - One read per cycle is sustained; responses stay in order; no backpressure.
  - Unmapped or out-of-range read: response still issued with rdata=0, and ERR_CNT increments.
  - Read-after-write (write at N, read at N+1) returns the new value.
- Simultaneous i_hrg_wr and i_hrg_rd in the same cycle:
  - The write is performed and the read is dropped (no response).
  - ERR_CNT increments by 1.
- Counters:
  - 32-bit, saturate at 32'hFFFF_FFFF.
  - A read of CMD_CNT/ERR_CNT returns the pre-clear value; the clear happens in stage 1.
  - An increment in the same cycle as the clear leaves the counter at 1.
  - If two ERR_CNT increment causes occur in one cycle, the counter adds 1 only.
- Asynchronous reset mid-read: the in-flight response is discarded; o_hrg_wr=0 until a new read completes.

Test Plan:
1. Release reset, read 0x0..0x9 back-to-back -> responses at N+2 each cycle:
   - 0x0 = 32'h0304_0000; 0x3 = 0x400; 0x4 = 0x3E8;
   - 0x7 returns 0 and ERR_CNT increments; 0x9 read last returns 1.
2. Write 0x1 = 32'hFFFF_FABC, then read 0x1 the next cycle:
   - ov_hcp_mid = 12'hABC one cycle after the write;
   - read returns 32'h0000_0ABC at N+2.
3. Write SOFT_RST = 32'h5A5A_A5A5, then rewrite after 5 cycles:
   - o_soft_rst_n low for 21 consecutive cycles total.
   - Write 32'h1234 instead -> no pulse, ERR_CNT = 1.
4. Pulse i_cmd_event 3 times, then read 0x8 with i_cmd_event asserted in stage 1:
   - response = 3; a following read returns 1.
5. Assert i_hrg_wr (addr 0x3, data 0x55) and i_hrg_rd together:
   - no response; SLOT_LEN = 0x55; ERR_CNT = 1.
   - Read with addr 19'h10 and addr_fix=1 -> response raddr=19'h10, addr_fix=1, rdata=0.
6. Issue a read, assert i_rst_n low in cycle N+1, release -> no o_hrg_wr pulse; all registers at reset values.

Source files
------------

// File: rtl/hcp_register_group.sv
// hcp_register_group
//   HCP register group on the HRG channel of the local access controller.
//   It holds the global configuration registers, the status registers and
//   the read-clear event counters. Read responses come back a fixed two
//   cycles after the read strobe. The block also drives the static
//   configuration outputs and a timed soft-reset pulse.
//
// Ports
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_hrg_wr/rd            write / read strobes (one cycle per access)
//   iv_hrg_wdata           write data
//   iv_hrg_addr            access address; valid only when addr[18:4] == 0
//   i_hrg_addr_fix         address-fix flag, echoed with the read response
//   o_hrg_wr               read-response valid
//   ov_hrg_raddr           address of the response
//   o_hrg_addr_fix         echoed address-fix flag
//   ov_hrg_rdata           read data
//   i_cmd_event            one-cycle pulse counted in CMD_CNT
//   iv_hw_state            live hardware state shown in HW_STATE
//   ov_hcp_mid, o_cfg_finish, o_report_en, ov_slot_len, ov_report_period
//                          static configuration outputs
//   o_soft_rst_n           soft-reset pulse, active low
module hcp_register_group #(
  parameter logic [31:0] P_VERSION         = 32'h0304_0000,
  parameter logic [15:0] P_SLOT_DEFAULT    = 16'd1024,
  parameter logic [15:0] P_PERIOD_DEFAULT  = 16'd1000,
  parameter int unsigned P_SOFT_RST_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_hrg_wr,
  input  logic [31:0] iv_hrg_wdata,
  input  logic [18:0] iv_hrg_addr,
  input  logic        i_hrg_addr_fix,
  input  logic        i_hrg_rd,
  output logic        o_hrg_wr,
  output logic [18:0] ov_hrg_raddr,
  output logic        o_hrg_addr_fix,
  output logic [31:0] ov_hrg_rdata,
  input  logic        i_cmd_event,
  input  logic [3:0]  iv_hw_state,
  output logic [11:0] ov_hcp_mid,
  output logic        o_cfg_finish,
  output logic        o_report_en,
  output logic [15:0] ov_slot_len,
  output logic [15:0] ov_report_period,
  output logic        o_soft_rst_n
);

  localparam int unsigned DATA_W = 32;
  localparam logic [31:0] SOFT_RST_KEY = 32'h5A5A_A5A5;
  localparam logic [7:0]  SR_LOAD      = 8'(P_SOFT_RST_CYCLES);

  localparam logic [3:0] IDX_VERSION  = 4'h0;
  localparam logic [3:0] IDX_HCP_MID  = 4'h1;
  localparam logic [3:0] IDX_CTRL     = 4'h2;
  localparam logic [3:0] IDX_SLOT_LEN = 4'h3;
  localparam logic [3:0] IDX_PERIOD   = 4'h4;
  localparam logic [3:0] IDX_SOFT_RST = 4'h5;
  localparam logic [3:0] IDX_HW_STATE = 4'h6;
  localparam logic [3:0] IDX_CMD_CNT  = 4'h8;
  localparam logic [3:0] IDX_ERR_CNT  = 4'h9;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Registered state
  logic [11:0]       hcp_mid_q;
  logic              cfg_finish_q, report_en_q;
  logic [15:0]       slot_len_q, period_q;
  logic [DATA_W-1:0] cmd_cnt_q, cmd_cnt_d;
  logic [DATA_W-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]        srst_cnt_q, srst_cnt_d;
  logic              soft_rst_n_q;

  // Read pipeline
  logic              vld_p0_q;
  logic [18:0]       addr_p0_q;
  logic              fix_p0_q;
  logic              vld_p1_q;
  logic [18:0]       addr_p1_q;
  logic              fix_p1_q;
  logic [DATA_W-1:0] rdata_p1_q, rdata_p1_d;
  logic              rd_err_p1, clr_cmd_p1, clr_err_p1;

  // Write decode
  logic wr_in_range;
  logic wr_mid, wr_ctrl, wr_slot, wr_period, wr_srst, wr_err;
  logic collide, err_inc;

  assign wr_in_range = (iv_hrg_addr[18:4] == 15'd0);
  assign collide     = i_hrg_wr & i_hrg_rd;

  always_comb begin
    wr_mid    = 1'b0;
    wr_ctrl   = 1'b0;
    wr_slot   = 1'b0;
    wr_period = 1'b0;
    wr_srst   = 1'b0;
    wr_err    = 1'b0;
    if (i_hrg_wr) begin
      if (!wr_in_range) begin
        wr_err = 1'b1;
      end else begin
        case (iv_hrg_addr[3:0])
          IDX_HCP_MID:  wr_mid    = 1'b1;
          IDX_CTRL:     wr_ctrl   = 1'b1;
          IDX_SLOT_LEN: wr_slot   = 1'b1;
          IDX_PERIOD:   wr_period = 1'b1;
          // Only the exact key arms the soft reset; anything else is a bad write.
          IDX_SOFT_RST: begin
            if (iv_hrg_wdata == SOFT_RST_KEY) wr_srst = 1'b1;
            else                              wr_err  = 1'b1;
          end
          default:      wr_err    = 1'b1;
        endcase
      end
    end
  end

  // Stage 1: decode the sampled read address and select the read data
  always_comb begin
    rdata_p1_d = '0;
    rd_err_p1  = 1'b0;
    clr_cmd_p1 = 1'b0;
    clr_err_p1 = 1'b0;
    if (vld_p0_q) begin
      if (addr_p0_q[18:4] != 15'd0) begin
        rd_err_p1 = 1'b1;
      end else begin
        case (addr_p0_q[3:0])
          IDX_VERSION:  rdata_p1_d = P_VERSION;
          IDX_HCP_MID:  rdata_p1_d = {20'd0, hcp_mid_q};
          IDX_CTRL:     rdata_p1_d = {30'd0, report_en_q, cfg_finish_q};
          IDX_SLOT_LEN: rdata_p1_d = {16'd0, slot_len_q};
          IDX_PERIOD:   rdata_p1_d = {16'd0, period_q};
          IDX_SOFT_RST: rdata_p1_d = '0;
          IDX_HW_STATE: rdata_p1_d = {28'd0, iv_hw_state};
          IDX_CMD_CNT: begin
            rdata_p1_d = cmd_cnt_q;
            clr_cmd_p1 = 1'b1;
          end
          IDX_ERR_CNT: begin
            rdata_p1_d = err_cnt_q;
            clr_err_p1 = 1'b1;
          end
          default:      rd_err_p1 = 1'b1;
        endcase
      end
    end
  end

  // Several error causes in one cycle still count once.
  assign err_inc = wr_err | collide | rd_err_p1;

  // Clear first, then increment: a clear and an event together leave 1.
  always_comb begin
    cmd_cnt_d = clr_cmd_p1 ? '0 : cmd_cnt_q;
    if (i_cmd_event) cmd_cnt_d = sat_inc(cmd_cnt_d);
    err_cnt_d = clr_err_p1 ? '0 : err_cnt_q;
    if (err_inc) err_cnt_d = sat_inc(err_cnt_d);
  end

  always_comb begin
    srst_cnt_d = srst_cnt_q;
    if (wr_srst)                 srst_cnt_d = SR_LOAD;
    else if (srst_cnt_q != 8'd0) srst_cnt_d = srst_cnt_q - 8'd1;
  end

  // Control and configuration state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hcp_mid_q    <= '0;
      cfg_finish_q <= 1'b0;
      report_en_q  <= 1'b0;
      slot_len_q   <= P_SLOT_DEFAULT;
      period_q     <= P_PERIOD_DEFAULT;
      cmd_cnt_q    <= '0;
      err_cnt_q    <= '0;
      srst_cnt_q   <= '0;
      soft_rst_n_q <= 1'b1;
    end else begin
      if (wr_mid)    hcp_mid_q  <= iv_hrg_wdata[11:0];
      if (wr_ctrl) begin
        cfg_finish_q <= iv_hrg_wdata[0];
        report_en_q  <= iv_hrg_wdata[1];
      end
      if (wr_slot)   slot_len_q <= iv_hrg_wdata[15:0];
      if (wr_period) period_q   <= iv_hrg_wdata[15:0];
      cmd_cnt_q    <= cmd_cnt_d;
      err_cnt_q    <= err_cnt_d;
      srst_cnt_q   <= srst_cnt_d;
      soft_rst_n_q <= (srst_cnt_d == 8'd0);
    end
  end

  // Stage 0: sample the read strobe; a read colliding with a write is dropped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) vld_p0_q <= 1'b0;
    else          vld_p0_q <= i_hrg_rd & ~i_hrg_wr;
  end

  always_ff @(posedge i_clk) begin
    addr_p0_q <= iv_hrg_addr;
    fix_p0_q  <= i_hrg_addr_fix;
  end

  // Stage 1 -> response registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1_q   <= 1'b0;
      addr_p1_q  <= '0;
      fix_p1_q   <= 1'b0;
      rdata_p1_q <= '0;
    end else begin
      vld_p1_q <= vld_p0_q;
      if (vld_p0_q) begin
        addr_p1_q  <= addr_p0_q;
        fix_p1_q   <= fix_p0_q;
        rdata_p1_q <= rdata_p1_d;
      end
    end
  end

  assign o_hrg_wr         = vld_p1_q;
  assign ov_hrg_raddr     = addr_p1_q;
  assign o_hrg_addr_fix   = fix_p1_q;
  assign ov_hrg_rdata     = rdata_p1_q;
  assign ov_hcp_mid       = hcp_mid_q;
  assign o_cfg_finish     = cfg_finish_q;
  assign o_report_en      = report_en_q;
  assign ov_slot_len      = slot_len_q;
  assign ov_report_period = period_q;
  assign o_soft_rst_n     = soft_rst_n_q;

endmodule

// File: tb/tb_hcp_register_group.sv
module tb_hcp_register_group;

  localparam logic [31:0] VERSION = 32'h0304_0000;
  localparam logic [31:0] KEY     = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hrg_wr = 1'b0, hrg_rd = 1'b0, addr_fix = 1'b0, cmd_event = 1'b0;
  logic [31:0] wdata = '0;
  logic [18:0] addr = '0;
  logic [3:0]  hw_state = '0;
  logic        rsp_wr, rsp_fix, cfg_finish, report_en, soft_rst_n;
  logic [18:0] rsp_addr;
  logic [31:0] rsp_data;
  logic [11:0] hcp_mid;
  logic [15:0] slot_len, report_period;

  always #5 clk = ~clk;

  hcp_register_group dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_hrg_wr(hrg_wr), .iv_hrg_wdata(wdata), .iv_hrg_addr(addr),
    .i_hrg_addr_fix(addr_fix), .i_hrg_rd(hrg_rd),
    .o_hrg_wr(rsp_wr), .ov_hrg_raddr(rsp_addr), .o_hrg_addr_fix(rsp_fix),
    .ov_hrg_rdata(rsp_data),
    .i_cmd_event(cmd_event), .iv_hw_state(hw_state),
    .ov_hcp_mid(hcp_mid), .o_cfg_finish(cfg_finish), .o_report_en(report_en),
    .ov_slot_len(slot_len), .ov_report_period(report_period),
    .o_soft_rst_n(soft_rst_n)
  );

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [11:0] m_mid;
  logic        m_fin, m_ren;
  logic [15:0] m_slot, m_period;
  logic [31:0] m_cmd, m_err;
  int          m_sr;
  // read waiting for its decode cycle, and the response now expected
  logic        p_vld;
  logic [18:0] p_addr;
  logic        p_fix;
  logic        e_wr, e_fix;
  logic [18:0] e_addr;
  logic [31:0] e_data;

  function automatic logic [31:0] sat1(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    m_mid = 0; m_fin = 0; m_ren = 0;
    m_slot = 16'd1024; m_period = 16'd1000;
    m_cmd = 0; m_err = 0; m_sr = 0;
    p_vld = 0; p_addr = 0; p_fix = 0;
    e_wr = 0; e_addr = 0; e_fix = 0; e_data = 0;
  endtask

  // Applies one clock edge worth of behaviour using the inputs held over it.
  task automatic model_update();
    bit err_ev = 0, clr_cmd = 0, clr_err = 0;
    logic [31:0] rv = 0;
    e_wr = p_vld;
    if (p_vld) begin
      if (p_addr[18:4] != 0) err_ev = 1;
      else case (p_addr[3:0])
        4'h0: rv = VERSION;
        4'h1: rv = {20'd0, m_mid};
        4'h2: rv = {30'd0, m_ren, m_fin};
        4'h3: rv = {16'd0, m_slot};
        4'h4: rv = {16'd0, m_period};
        4'h5: rv = 0;
        4'h6: rv = {28'd0, hw_state};
        4'h8: begin rv = m_cmd; clr_cmd = 1; end
        4'h9: begin rv = m_err; clr_err = 1; end
        default: err_ev = 1;
      endcase
      e_addr = p_addr; e_fix = p_fix; e_data = rv;
    end
    if (hrg_wr) begin
      if (hrg_rd) err_ev = 1;
      if (addr[18:4] != 0) err_ev = 1;
      else case (addr[3:0])
        4'h1: m_mid = wdata[11:0];
        4'h2: begin m_fin = wdata[0]; m_ren = wdata[1]; end
        4'h3: m_slot = wdata[15:0];
        4'h4: m_period = wdata[15:0];
        4'h5: if (wdata == KEY) m_sr = 17; else err_ev = 1;
        default: err_ev = 1;
      endcase
    end
    // m_sr counts remaining low cycles plus one so that one decrement per edge is uniform
    if (m_sr > 0) m_sr--;
    if (clr_cmd) m_cmd = 0;
    if (cmd_event) m_cmd = sat1(m_cmd);
    if (clr_err) m_err = 0;
    if (err_ev) m_err = sat1(m_err);
    p_vld = hrg_rd & ~hrg_wr;
    p_addr = addr; p_fix = addr_fix;
  endtask

  task automatic check_all();
    chk("rsp_vld", rsp_wr, e_wr);
    if (e_wr) begin
      chk("rsp_addr", rsp_addr, e_addr);
      chk("rsp_fix", rsp_fix, e_fix);
      chk("rsp_data", rsp_data, e_data);
    end
    chk("cfg", {hcp_mid, cfg_finish, report_en, slot_len, report_period},
               {m_mid, m_fin, m_ren, m_slot, m_period});
    chk("soft_rst_n", soft_rst_n, (m_sr == 0));
  endtask

  bit win = 0;
  int lowcnt = 0;

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
    if (win && !soft_rst_n) lowcnt++;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [18:0] a,
                       input logic [31:0] d, input logic fx, input logic ev);
    hrg_wr = wr; hrg_rd = rd; addr = a; wdata = d; addr_fix = fx; cmd_event = ev;
    hw_state = 4'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  task automatic do_wr(input logic [18:0] a, input logic [31:0] d);
    drive(1, 0, a, d, 0, 0); step();
  endtask

  task automatic do_rd(input logic [18:0] a);
    drive(0, 1, a, 0, 0, 0); step();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    idle(2);

    // 1: back-to-back reads of 0x0..0x9
    for (int i = 0; i < 10; i++) do_rd(19'(i));
    idle(3);

    // 2: write HCP_MID then read it the next cycle
    do_wr(19'h1, 32'hFFFF_FABC);
    chk("mid_after_wr", hcp_mid, 12'hABC);
    do_rd(19'h1);
    idle(3);

    // 3: soft reset with rewrite after 5 cycles
    do_rd(19'h9); idle(3);
    win = 1; lowcnt = 0;
    do_wr(19'h5, KEY);
    idle(4);
    do_wr(19'h5, KEY);
    idle(30);
    win = 0;
    chk("pulse_len", lowcnt, 21);
    win = 1; lowcnt = 0;
    do_wr(19'h5, 32'h1234);
    idle(20);
    win = 0;
    chk("bad_key_pulse", lowcnt, 0);
    do_rd(19'h9); idle(3);

    // 4: three command events, then a read-clear racing an event
    do_rd(19'h8); idle(3);
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 1); step(); end
    do_rd(19'h8);
    drive(0, 0, 0, 0, 0, 1); step();
    idle(1);
    do_rd(19'h8); idle(3);

    // 5: simultaneous write and read, then an out-of-range read with addr_fix
    do_rd(19'h9); idle(3);
    drive(1, 1, 19'h3, 32'h55, 0, 0); step();
    idle(3);
    chk("slot_collide", slot_len, 16'h55);
    do_rd(19'h9); idle(3);
    drive(0, 1, 19'h10, 0, 1, 0); step();
    idle(3);

    // 6: asynchronous reset while a read is in flight
    do_wr(19'h2, 32'h3);
    do_rd(19'h0);
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_all();
    rst_n = 1'b1;
    idle(4);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [18:0] a;
      logic [31:0] d;
      logic w, r;
      a = 19'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) a[18:4] = 15'($urandom);
      w = ($urandom_range(0, 9) < 3);
      r = ($urandom_range(0, 9) < 4);
      d = $urandom;
      if (w && a == 19'h5 && $urandom_range(0, 1) == 1) d = KEY;
      drive(w, r, a, d, 1'($urandom), 1'($urandom));
      step();
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
